// File: rtl/fifo_led_player.sv
// fifo_led_player: paced reader for a standard-mode (non-FWFT) FIFO.
// Each popped word is shown on the LEDs for hold_cycles+3 cycles in total:
// one IDLE cycle that issues the read, one FETCH cycle while the FIFO's
// registered data arrives, and hold_cycles+1 SHOW cycles.
// Optional feature macro: FIFO_LED_PLAYER_BLINK_EN. When it is defined, the
// last word blinks on the LEDs while the block waits in IDLE on an empty FIFO.
//
// Handshake: fifo_rd_en is a single-cycle request that is issued only in IDLE,
// only when en=1, fifo_empty=0 and rst=0. The FIFO presents the word on
// fifo_dout in the following cycle, which is always FETCH, so no separate
// valid signal is needed.
module fifo_led_player #(
  parameter int DATA_W = 4,
  parameter int HOLD_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] led,
  output logic              busy,
  output logic              word_strobe,
  output logic [15:0]       word_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DATA_W-1:0] last_word;
  logic              hold_zero;

  assign hold_zero = (hold_cnt == '0);

  // Next-state decode and the combinational read strobe.
  always_comb begin
    state_next = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && en && !fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = SHOW;
      end
      SHOW: begin
        if (hold_zero) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // busy is a registered copy of "next state is not IDLE", so it is high
  // exactly while the current state is FETCH or SHOW.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
    end
  end

  // Word capture, hold counter, strobe and word counter. The word is taken
  // from fifo_dout only in FETCH; a read cut short by rst is simply lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_word   <= '0;
      hold_cnt    <= '0;
      word_count  <= '0;
      word_strobe <= 1'b0;
    end else begin
      word_strobe <= 1'b0;
      case (state)
        FETCH: begin
          last_word   <= fifo_dout;
          hold_cnt    <= hold_cycles;
          word_count  <= word_count + 16'd1;
          word_strobe <= 1'b1;
        end
        SHOW: begin
          if (!hold_zero) begin
            hold_cnt <= hold_cnt - 1'b1;
          end
`ifdef FIFO_LED_PLAYER_BLINK_EN
          else begin
            // Leaving SHOW: arm the counter to time the first blink phase.
            hold_cnt <= hold_cycles;
          end
`endif
        end
        IDLE: begin
`ifdef FIFO_LED_PLAYER_BLINK_EN
          // The hold counter doubles as the blink phase timer while waiting.
          if (fifo_empty) begin
            if (hold_zero) begin
              hold_cnt <= hold_cycles;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
`endif
        end
        default: begin
          hold_cnt <= hold_cnt;
        end
      endcase
    end
  end

`ifdef FIFO_LED_PLAYER_BLINK_EN
  logic blink_on;

  // Blink phase: starts dark on every entry to IDLE, flips when a phase ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_on <= 1'b0;
    end else if (state == SHOW) begin
      blink_on <= 1'b0;
    end else if (state == IDLE && fifo_empty && hold_zero) begin
      blink_on <= ~blink_on;
    end
  end

  // LEDs blank during the dark phase of an empty-FIFO wait.
  assign led = (state == IDLE && fifo_empty && !blink_on) ? '0 : last_word;
`else
  // LEDs show the last fetched word steadily.
  assign led = last_word;
`endif

endmodule

// File: tb/tb_fifo_led_player.sv
// tb_fifo_led_player: directed bench for fifo_led_player with a behavioural
// standard-mode FIFO. Honours FIFO_LED_PLAYER_BLINK_EN for the idle LED check.
module tb_fifo_led_player;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [23:0] hold_cycles = '0;
  logic        fifo_empty = 1'b1;
  logic [3:0]  fifo_dout = '0;
  logic        fifo_rd_en;
  logic [3:0]  led;
  logic        busy;
  logic        word_strobe;
  logic [15:0] word_count;

  logic        push_req = 1'b0;
  logic [3:0]  push_data = '0;

  int checks = 0;
  int errors = 0;

  // FIFO model bookkeeping, written only by the model process.
  logic [3:0] fifo_q[$];
  int         rd_total = 0;
  int         bad_rd = 0;
  logic       prev_rd = 1'b0;

  fifo_led_player #(
    .DATA_W(4),
    .HOLD_W(24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .hold_cycles(hold_cycles),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .led        (led),
    .busy       (busy),
    .word_strobe(word_strobe),
    .word_count (word_count)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Standard-mode FIFO: data appears the cycle after rd_en; pushes land on
  // the same edge. Reads while empty or back-to-back are tallied as bad.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_total++;
      if (fifo_q.size() == 0) begin
        bad_rd++;
      end else begin
        fifo_dout <= fifo_q.pop_front();
      end
      if (prev_rd) bad_rd++;
    end
    prev_rd = fifo_rd_en;
    if (push_req) fifo_q.push_back(push_data);
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int busy_n;
    int strobe_n;
    int rd_n;
    int rd_base;
    int s_n;
    logic [3:0] s_led[8];
    int s_cyc[8];

    // Reset with data already in the FIFO.
    @(negedge clk);
    push_req = 1'b1;
    push_data = 4'hA;
    en = 1'b1;
    @(negedge clk);
    push_req = 1'b0;
    chk("rst_rd_en_a", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    chk("rst_rd_en_b", {31'd0, fifo_rd_en}, 32'd0);
    en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_led", {28'd0, led}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_strobe", {31'd0, word_strobe}, 32'd0);
    chk("rst_count", {16'd0, word_count}, 32'd0);
    chk("rst_rd_en_idle", {31'd0, fifo_rd_en}, 32'd0);

    // Single word 4'hA, hold 5: busy for 7 cycles, one strobe.
    hold_cycles = 24'd5;
    en = 1'b1;
    #1;
    chk("single_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    busy_n = 0;
    strobe_n = 0;
    rd_n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      busy_n += int'(busy);
      strobe_n += int'(word_strobe);
      rd_n += int'(fifo_rd_en);
      if (i == 2) begin
        chk("single_led", {28'd0, led}, 32'hA);
        chk("single_strobe", {31'd0, word_strobe}, 32'd1);
      end
    end
    chk("single_busy_cycles", busy_n, 32'd7);
    chk("single_strobes", strobe_n, 32'd1);
    chk("single_no_more_rd", rd_n, 32'd0);
    chk("single_count", {16'd0, word_count}, 32'd1);

    // Stream 1,2,3 with hold 0: strobes exactly 3 cycles apart.
    hold_cycles = 24'd0;
    s_n = 0;
    rd_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 3) begin
        push_req = 1'b1;
        push_data = 4'(c + 1);
      end else begin
        push_req = 1'b0;
      end
      if (word_strobe && s_n < 8) begin
        s_led[s_n] = led;
        s_cyc[s_n] = c;
        s_n++;
      end
      rd_n += int'(fifo_rd_en);
      @(negedge clk);
    end
    push_req = 1'b0;
    chk("stream_strobes", s_n, 32'd3);
    chk("stream_led0", {28'd0, s_led[0]}, 32'h1);
    chk("stream_led1", {28'd0, s_led[1]}, 32'h2);
    chk("stream_led2", {28'd0, s_led[2]}, 32'h3);
    chk("stream_first_at", s_cyc[0], 32'd3);
    chk("stream_gap01", s_cyc[1] - s_cyc[0], 32'd3);
    chk("stream_gap12", s_cyc[2] - s_cyc[1], 32'd3);
    chk("stream_rd_pulses", rd_n, 32'd3);
    chk("stream_count", {16'd0, word_count}, 32'd4);

    // Pause: drop en while 4'h5 is showing, with 4'h7 waiting behind it.
    hold_cycles = 24'd4;
    push_req = 1'b1;
    push_data = 4'h5;
    @(negedge clk);
    push_data = 4'h7;
    chk("pause_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    push_req = 1'b0;
    @(negedge clk);
    chk("pause_led5", {28'd0, led}, 32'h5);
    chk("pause_strobe", {31'd0, word_strobe}, 32'd1);
    @(negedge clk);
    en = 1'b0;
    rd_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rd_n += int'(fifo_rd_en);
    end
    chk("pause_no_rd", rd_n, 32'd0);
    chk("pause_idle", {31'd0, busy}, 32'd0);
    chk("pause_led_held", {28'd0, led}, 32'h5);
    chk("pause_fifo_nonempty", {31'd0, fifo_empty}, 32'd0);
    chk("pause_count", {16'd0, word_count}, 32'd5);
    en = 1'b1;
    #1;
    chk("resume_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("resume_led7", {28'd0, led}, 32'h7);
    chk("resume_strobe", {31'd0, word_strobe}, 32'd1);
    chk("resume_count", {16'd0, word_count}, 32'd6);

    // Reset asserted in the FETCH cycle of 4'hC.
    repeat (8) @(negedge clk);
    push_req = 1'b1;
    push_data = 4'hC;
    @(negedge clk);
    push_req = 1'b0;
    chk("midrst_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    chk("midrst_fetch_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_rd_en_in_rst", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    chk("midrst_led", {28'd0, led}, 32'd0);
    chk("midrst_count", {16'd0, word_count}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_strobe", {31'd0, word_strobe}, 32'd0);
    rst = 1'b0;
    strobe_n = 0;
    busy_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      strobe_n += int'(word_strobe);
      busy_n += int'(led != 4'h0);
    end
    chk("midrst_c_never_strobed", strobe_n, 32'd0);
    chk("midrst_c_never_shown", busy_n, 32'd0);

    // Idle display after 4'h6 with hold 3 and an empty FIFO.
    hold_cycles = 24'd3;
    push_req = 1'b1;
    push_data = 4'h6;
    @(negedge clk);
    push_req = 1'b0;
    chk("idle6_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("idle6_led", {28'd0, led}, 32'h6);
    repeat (4) @(negedge clk);
`ifdef FIFO_LED_PLAYER_BLINK_EN
    chk("blink_ph0_first", {28'd0, led}, 32'h0);
    repeat (3) @(negedge clk);
    chk("blink_ph0_last", {28'd0, led}, 32'h0);
    @(negedge clk);
    chk("blink_ph1_first", {28'd0, led}, 32'h6);
    repeat (3) @(negedge clk);
    chk("blink_ph1_last", {28'd0, led}, 32'h6);
    @(negedge clk);
    chk("blink_ph2_first", {28'd0, led}, 32'h0);
`else
    chk("steady_a", {28'd0, led}, 32'h6);
    repeat (4) @(negedge clk);
    chk("steady_b", {28'd0, led}, 32'h6);
    repeat (4) @(negedge clk);
    chk("steady_c", {28'd0, led}, 32'h6);
`endif
    push_req = 1'b1;
    push_data = 4'h9;
    @(negedge clk);
    push_req = 1'b0;
    chk("next9_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("next9_led", {28'd0, led}, 32'h9);
    chk("next9_strobe", {31'd0, word_strobe}, 32'd1);
    chk("next9_count", {16'd0, word_count}, 32'd2);
    repeat (10) @(negedge clk);
    chk("next9_led_after", {28'd0, led}, 32'h9);

    // Read-port protocol over the whole run.
    rd_base = rd_total;
    chk("total_reads", rd_base, 32'd9);
    chk("bad_reads", bad_rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_led_player.md
# fifo_led_player

Read side of the pushbutton-fed pattern FIFO. Pops 4-bit words from a coregen standard-mode (non-FWFT) FIFO and shows each word on the board LEDs for a programmable hold time. Sits between the FIFO's read port and the LED pins, replacing direct `rd_en`/`dout` wiring with a paced rd_en/empty handshake.

## Interface
- `DATA_W`, default 4: FIFO word width, equal to the LED count.
- `HOLD_W`, default 24: width of the hold counter and of `hold_cycles`.
- `clk` input, 1 bit: 200 MHz system clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `en` input, 1 bit: playback enable, level-sensitive.
- `hold_cycles` input, `HOLD_W` bits: extra display cycles per word. Sampled in FETCH.
- `fifo_empty` input, 1 bit: FIFO empty flag.
- `fifo_dout` input, `DATA_W` bits: FIFO read data. Valid the cycle after `fifo_rd_en`.
- `fifo_rd_en` output, 1 bit: FIFO read strobe, single-cycle pulses only.
- `led` output, `DATA_W` bits: displayed word.
- `busy` output, 1 bit: high in FETCH and SHOW.
- `word_strobe` output, 1 bit: 1-cycle pulse, high in the first cycle a new word is on `led`.
- `word_count` output, 16 bits: words displayed since reset. Wraps from 0xFFFF to 0.

## Operation
- FSM states: IDLE, FETCH, SHOW. Reset state is IDLE.
- IDLE:
  - If `en && !fifo_empty`: drive `fifo_rd_en`=1 combinationally this cycle, go to FETCH.
  - Otherwise stay in IDLE with `fifo_rd_en`=0.
- FETCH:
  - `fifo_dout` is valid this cycle.
  - At the clock edge: latch `led <= fifo_dout`, `last_word <= fifo_dout`, hold counter `<= hold_cycles`, `word_count += 1`, `word_strobe <= 1`. Go to SHOW.
- SHOW:
  - If counter is 0, go to IDLE.
  - Otherwise decrement the counter.
  - `en` and `fifo_empty` are ignored here.
- `fifo_rd_en` is asserted only in IDLE. The block never reads an empty FIFO and never issues back-to-back reads.
- `en` deasserted during FETCH or SHOW: the current word completes its full hold, then the block parks in IDLE with `led` unchanged.
- `hold_cycles` changes take effect only at the next FETCH.
- Reset mid-operation, on the same edge:
  - State goes to IDLE; `led`, `word_count`, `last_word` and the counter clear.
  - `fifo_rd_en` is 0 in every cycle `rst` is high.
  - A read issued the cycle before reset is discarded; its data is not latched.

## Timing
- Reset values: `led`=0, `fifo_rd_en`=0, `busy`=0, `word_strobe`=0, `word_count`=0.
- Latency: `fifo_rd_en` in cycle N → `led` and `word_strobe` change at the edge ending cycle N+1, visible in cycle N+2.
- Per-word period with a non-empty FIFO and `en`=1: `hold_cycles`+3 cycles.
  - Made up of IDLE 1 + FETCH 1 + SHOW `hold_cycles`+1.
  - Minimum period is 3 cycles (`hold_cycles`=0).
- `busy` is registered from the state: high from the cycle after `fifo_rd_en` through the last SHOW cycle.
- `fifo_empty` rising in the same cycle as an IDLE check: no read is issued.

## Configuration
- Macro `FIFO_LED_PLAYER_BLINK_EN`.
- Defined: while in IDLE with `fifo_empty`=1, `led` alternates between `last_word` and 0.
  - Each phase lasts `hold_cycles`+1 cycles, timed by the hold counter.
  - The first phase after entering IDLE shows 0.
  - The next FETCH overwrites `led` regardless of phase.
  - `word_strobe` and `word_count` are unaffected by blinking.
- Not defined: `led` holds `last_word` steadily in IDLE. The blink logic is absent.

## Test plan
- Reset: `rst`=1 for 2 cycles with the FIFO model holding data → `fifo_rd_en`=0 throughout; `led`=0, `busy`=0, `word_count`=0 on the first cycle after release.
- Single word: push 4'hA, `hold_cycles`=5, `en`=1 → one `fifo_rd_en` pulse; `led`=4'hA two cycles later with one `word_strobe`; `busy` high 7 cycles; `word_count`=1.
- Stream: push 4'h1, 4'h2, 4'h3, `hold_cycles`=0 → `led` sequence 1,2,3 with strobes exactly 3 cycles apart; exactly 3 rd_en pulses; no read while `fifo_empty`=1.
- Pause: drop `en` mid-SHOW of word 4'h5 → word completes its hold; no further `fifo_rd_en`; `led`=4'h5 held (macro undefined); raising `en` resumes with the next word.
- Reset mid-run: assert `rst` in the FETCH cycle of 4'hC → `led`=0 the next cycle; 4'hC never displayed; `word_count`=0.
- Blink (macro defined): after 4'h6, FIFO empty, `hold_cycles`=3 → `led` pattern 0,6,0,6 in 4-cycle phases; pushing 4'h9 stops blinking; `led`=9.
